// File: rtl/reg_dump.sv
// reg_dump: sequential register-file read-out engine streaming bytes over valid/ready.
// Optional: define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module reg_dump #(
  parameter int PW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [PW-1:0] i_first_addr,
  input  logic [PW-1:0] i_last_addr,
  output logic [PW:0]   o_rd_addr,
  input  logic [7:0]    i_rd_data,
  output logic [7:0]    o_dout,
  output logic          o_dout_valid,
  input  logic          i_dout_ready,
  output logic          o_dout_last,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND
  } state_t;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic LP_DATA_LAST = 1'b0;
`else
  localparam logic LP_DATA_LAST = 1'b1;
`endif

  localparam logic [PW:0] LP_ONE = (PW+1)'(1);
  localparam logic [PW:0] LP_TWO = (PW+1)'(2);

  state_t        r_state, w_state_nx;
  logic [PW-1:0] r_addr, w_addr_nx;
  logic [PW:0]   r_cnt, w_cnt_nx;
  logic [7:0]    r_dout, w_dout_nx;
  logic          r_valid, w_valid_nx;
  logic          r_last, w_last_nx;
  logic          r_busy, w_busy_nx;
  logic          r_done, w_done_nx;
  logic          w_xfer;
  logic [PW:0]   w_range;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]    r_csum, w_csum_nx;
  logic          r_ck, w_ck_nx;
`endif

  assign w_xfer  = r_valid & i_dout_ready;
  assign w_range = {1'b0, i_last_addr - i_first_addr} + LP_ONE;

  // Next-state and datapath update decode
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_cnt_nx   = r_cnt;
    w_dout_nx  = r_dout;
    w_valid_nx = r_valid;
    w_last_nx  = r_last;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    w_csum_nx  = r_csum;
    w_ck_nx    = r_ck;
`endif
    unique case (r_state)
      S_IDLE: begin
        // a start coinciding with the done pulse belongs to the old dump
        if (i_start && !r_done) begin
          w_addr_nx  = i_first_addr;
          w_cnt_nx   = w_range;
          w_busy_nx  = 1'b1;
          w_state_nx = S_FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum_nx  = 8'h00;
          w_ck_nx    = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        w_dout_nx  = i_rd_data;
        w_valid_nx = 1'b1;
        w_addr_nx  = r_addr + 1'b1;
        w_last_nx  = LP_DATA_LAST & (r_cnt == LP_ONE);
        w_state_nx = S_SEND;
      end
      S_SEND: begin
        if (w_xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
          if (r_ck) begin
            w_valid_nx = 1'b0;
            w_last_nx  = 1'b0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_ck_nx    = 1'b0;
            w_state_nx = S_IDLE;
          end else begin
            w_csum_nx = r_csum ^ r_dout;
            w_cnt_nx  = r_cnt - LP_ONE;
            if (r_cnt == LP_ONE) begin
              w_dout_nx = r_csum ^ r_dout;
              w_last_nx = 1'b1;
              w_ck_nx   = 1'b1;
            end else begin
              w_dout_nx = i_rd_data;
              w_addr_nx = r_addr + 1'b1;
              w_last_nx = 1'b0;
            end
          end
`else
          w_cnt_nx = r_cnt - LP_ONE;
          if (r_cnt == LP_ONE) begin
            w_valid_nx = 1'b0;
            w_last_nx  = 1'b0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_dout_nx = i_rd_data;
            w_addr_nx = r_addr + 1'b1;
            w_last_nx = LP_DATA_LAST & (r_cnt == LP_TWO);
          end
`endif
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_dout  <= 8'h00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_cnt   <= w_cnt_nx;
      r_dout  <= w_dout_nx;
      r_valid <= w_valid_nx;
      r_last  <= w_last_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Checksum accumulator and checksum-phase flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= 8'h00;
      r_ck   <= 1'b0;
    end else begin
      r_csum <= w_csum_nx;
      r_ck   <= w_ck_nx;
    end
  end
`endif

  assign o_rd_addr    = {1'b0, r_addr};
  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;
  assign o_dout_last  = r_last;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed self-checking bench for reg_dump.
// Follows REG_DUMP_CHECKSUM_EN the same way as the design.
module tb_reg_dump;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [16];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr[3:0]];

  reg_dump #(.PW(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_first_addr (first_addr),
    .i_last_addr  (last_addr),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_dout_last  (dout_last),
    .o_busy       (busy),
    .o_done       (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input logic [3:0] f, input logic [3:0] l);
    logic [7:0] exp_q [$];
    logic [7:0] x;
    logic [3:0] d;
    logic [3:0] a;
    int n;
    int got;
    int guard;
    d = l - f;
    n = int'(d) + 1;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      a = f + 4'(k);
      exp_q.push_back(mem[a]);
      x ^= mem[a];
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    dout_ready = 1'b1;
    first_addr = f;
    last_addr  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat1_valid", 32'(dout_valid), 32'd0);
    chk("lat1_busy", 32'(busy), 32'd1);
    tick();
    chk("lat2_valid", 32'(dout_valid), 32'd1);
    got = 0;
    guard = 0;
    while (got < exp_q.size() && guard < 100) begin
      if (dout_valid && dout_ready) begin
        chk($sformatf("byte%0d_%0h_%0h", got, f, l), 32'(dout), 32'(exp_q[got]));
        chk($sformatf("last%0d_%0h_%0h", got, f, l), 32'(dout_last),
            32'(got == exp_q.size() - 1));
        got++;
      end
      tick();
      guard++;
    end
    chk("dump_rate", 32'(guard), 32'(exp_q.size()));
    chk("done_hi", 32'(done), 32'd1);
    chk("busy_lo", 32'(busy), 32'd0);
    chk("valid_lo", 32'(dout_valid), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    first_addr = 4'd0;
    last_addr = 4'd0;
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    #12;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // full dump 0..15
    run_dump(4'd0, 4'd15);
    // wrapping range 14..1
    run_dump(4'd14, 4'd1);

    // single byte with ready 0,0,1
    mem[5] = 8'hA5;
    dout_ready = 1'b0;
    first_addr = 4'd5;
    last_addr = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("one_dout%0d", c), 32'(dout), 32'hA5);
      chk($sformatf("one_valid%0d", c), 32'(dout_valid), 32'd1);
`ifdef REG_DUMP_CHECKSUM_EN
      chk($sformatf("one_last%0d", c), 32'(dout_last), 32'd0);
`else
      chk($sformatf("one_last%0d", c), 32'(dout_last), 32'd1);
`endif
      if (c == 2) dout_ready = 1'b1;
      tick();
    end
`ifdef REG_DUMP_CHECKSUM_EN
    chk("one_ck", 32'(dout), 32'hA5);
    chk("one_ck_last", 32'(dout_last), 32'd1);
    tick();
`endif
    chk("one_done", 32'(done), 32'd1);
    chk("one_valid_lo", 32'(dout_valid), 32'd0);
    tick();

    // asynchronous reset mid-dump
    first_addr = 4'd0;
    last_addr = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("arst_idle%0d", c), 32'({dout_valid, busy}), 32'd0);
    end

    // start while busy and during done is ignored
    first_addr = 4'd0;
    last_addr = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!done && guard < 50) begin
      tick();
      guard++;
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy0", 32'(busy), 32'd0);
    tick();
    chk("ign_busy1", 32'(busy), 32'd0);
    chk("ign_valid", 32'(dout_valid), 32'd0);
    run_dump(4'd2, 4'd4);

    // write to next register while stalled
    mem[8] = 8'h88;
    mem[9] = 8'h99;
    dout_ready = 1'b0;
    first_addr = 4'd8;
    last_addr = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stall_b8", 32'(dout), 32'h88);
    mem[9] = 8'h3C;
    tick();
    chk("stall_hold", 32'(dout), 32'h88);
    dout_ready = 1'b1;
    tick();
    chk("stall_b9", 32'(dout), 32'h3C);
`ifdef REG_DUMP_CHECKSUM_EN
    chk("stall_b9_last", 32'(dout_last), 32'd0);
    tick();
    chk("stall_ck", 32'(dout), 32'hB4);
    chk("stall_ck_last", 32'(dout_last), 32'd1);
`else
    chk("stall_b9_last", 32'(dout_last), 32'd1);
`endif
    tick();
    chk("stall_done", 32'(done), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
